// File: rtl/rvfi_monitor_rv32imc.sv
// RVFI retirement checker for an RV32IMC core: checks order, PC flow, register
// consistency, memory masks and halt discipline; latches the first error code.
module rvfi_monitor_rv32imc #(
    parameter int unsigned XLEN      = 32,
    parameter bit          CHECK_REG = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            rvfi_valid,
    input  logic [63:0]     rvfi_order,
    input  logic [31:0]     rvfi_insn,
    input  logic            rvfi_trap,
    input  logic            rvfi_halt,
    input  logic            rvfi_intr,
    input  logic [1:0]      rvfi_mode,
    input  logic [4:0]      rvfi_rs1_addr,
    input  logic [4:0]      rvfi_rs2_addr,
    input  logic [XLEN-1:0] rvfi_rs1_rdata,
    input  logic [XLEN-1:0] rvfi_rs2_rdata,
    input  logic [4:0]      rvfi_rd_addr,
    input  logic [XLEN-1:0] rvfi_rd_wdata,
    input  logic [XLEN-1:0] rvfi_pc_rdata,
    input  logic [XLEN-1:0] rvfi_pc_wdata,
    input  logic [XLEN-1:0] rvfi_mem_addr,
    input  logic [3:0]      rvfi_mem_rmask,
    input  logic [3:0]      rvfi_mem_wmask,
    input  logic [XLEN-1:0] rvfi_mem_rdata,
    input  logic [XLEN-1:0] rvfi_mem_wdata,
    input  logic            rvfi_mem_extamo,
    output logic [15:0]     errcode
);

    localparam int unsigned NREG = 32;

    localparam logic [15:0] E_ORDER    = 16'h0101;
    localparam logic [15:0] E_PC_FLOW  = 16'h0102;
    localparam logic [15:0] E_PC_ALIGN = 16'h0103;
    localparam logic [15:0] E_RS1      = 16'h0201;
    localparam logic [15:0] E_RS2      = 16'h0202;
    localparam logic [15:0] E_X0_WR    = 16'h0203;
    localparam logic [15:0] E_MASK     = 16'h0301;
    localparam logic [15:0] E_MIXED    = 16'h0302;
    localparam logic [15:0] E_MISALIGN = 16'h0303;
    localparam logic [15:0] E_HALT     = 16'h0401;
    localparam logic [15:0] E_TRAP     = 16'h0402;

    logic [15:0]     r_errcode;
    logic            r_first;
    logic            r_halted;
    logic [63:0]     r_prev_order;
    logic [XLEN-1:0] r_prev_pc;
    logic [NREG-1:0] r_shadow_vld;
    logic [XLEN-1:0] r_shadow [NREG];

    logic            w_order_err;
    logic            w_pc_flow_err;
    logic            w_pc_align_err;
    logic            w_rs1_err;
    logic            w_rs2_err;
    logic            w_x0_err;
    logic            w_mask_err;
    logic            w_mixed_err;
    logic            w_misalign_err;
    logic            w_halt_err;
    logic            w_trap_err;
    logic [15:0]     w_err_code;
    logic            w_unused;

    function automatic logic mask_legal(input logic [3:0] m);
        return (m == 4'b0000) || (m == 4'b0001) || (m == 4'b0010) || (m == 4'b0100) ||
               (m == 4'b1000) || (m == 4'b0011) || (m == 4'b1100) || (m == 4'b1111);
    endfunction

    // Register read matches x0 or the last value retired into that register
    function automatic logic rs_mismatch(input logic [4:0] addr, input logic [XLEN-1:0] data,
                                         input logic [NREG-1:0] vld,
                                         input logic [XLEN-1:0] shadow_val);
        if (addr == 5'd0) begin
            return data != '0;
        end
        return vld[addr] && (data != shadow_val);
    endfunction

    assign w_unused = ^{rvfi_insn, rvfi_mode, rvfi_mem_rdata, rvfi_mem_wdata};

    assign w_order_err    = r_first ? (rvfi_order != 64'd0) : (rvfi_order != r_prev_order + 64'd1);
    assign w_pc_flow_err  = !r_first && (rvfi_pc_rdata != r_prev_pc);
    assign w_pc_align_err = rvfi_pc_rdata[0] | rvfi_pc_wdata[0];
    assign w_rs1_err      = CHECK_REG && rs_mismatch(rvfi_rs1_addr, rvfi_rs1_rdata, r_shadow_vld,
                                                     r_shadow[rvfi_rs1_addr]);
    assign w_rs2_err      = CHECK_REG && rs_mismatch(rvfi_rs2_addr, rvfi_rs2_rdata, r_shadow_vld,
                                                     r_shadow[rvfi_rs2_addr]);
    assign w_x0_err       = CHECK_REG && (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != '0);
    assign w_mask_err     = !mask_legal(rvfi_mem_rmask) || !mask_legal(rvfi_mem_wmask);
    assign w_mixed_err    = (rvfi_mem_rmask != 4'd0) && (rvfi_mem_wmask != 4'd0) && !rvfi_mem_extamo;
    assign w_misalign_err = (rvfi_mem_addr[1:0] != 2'd0) && ((rvfi_mem_rmask | rvfi_mem_wmask) != 4'd0);
    assign w_halt_err     = r_halted;
    assign w_trap_err     = rvfi_trap | rvfi_intr;

    // Lowest numbered code wins when several checks fire on one beat
    always_comb begin
        w_err_code = 16'h0000;
        if (rvfi_valid) begin
            if      (w_order_err)    w_err_code = E_ORDER;
            else if (w_pc_flow_err)  w_err_code = E_PC_FLOW;
            else if (w_pc_align_err) w_err_code = E_PC_ALIGN;
            else if (w_rs1_err)      w_err_code = E_RS1;
            else if (w_rs2_err)      w_err_code = E_RS2;
            else if (w_x0_err)       w_err_code = E_X0_WR;
            else if (w_mask_err)     w_err_code = E_MASK;
            else if (w_mixed_err)    w_err_code = E_MIXED;
            else if (w_misalign_err) w_err_code = E_MISALIGN;
            else if (w_halt_err)     w_err_code = E_HALT;
            else if (w_trap_err)     w_err_code = E_TRAP;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_errcode    <= 16'h0000;
            r_first      <= 1'b1;
            r_halted     <= 1'b0;
            r_prev_order <= 64'd0;
            r_prev_pc    <= '0;
            r_shadow_vld <= '0;
        end else begin
            if (rvfi_halt) begin
                r_halted <= 1'b1;
            end
            if (rvfi_valid) begin
                if (r_errcode == 16'h0000) begin
                    r_errcode <= w_err_code;
                end
                r_prev_order <= rvfi_order;
                r_prev_pc    <= rvfi_pc_wdata;
                r_first      <= 1'b0;
                if (rvfi_rd_addr != 5'd0) begin
                    r_shadow_vld[rvfi_rd_addr] <= 1'b1;
                end
            end
        end
    end

    // Shadow data needs no reset: the valid bits gate every comparison
    always_ff @(posedge clock) begin
        if (rvfi_valid && (rvfi_rd_addr != 5'd0)) begin
            r_shadow[rvfi_rd_addr] <= rvfi_rd_wdata;
        end
    end

    assign errcode = r_errcode;

endmodule

// File: tb/tb_rvfi_monitor_rv32imc.sv
// Directed bench for rvfi_monitor_rv32imc: a rule-list reference model is compared
// against errcode every cycle, plus hand-computed literal expectations.
module tb_rvfi_monitor_rv32imc;

    logic        clock = 1'b0;
    logic        reset;
    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic        rvfi_trap;
    logic        rvfi_halt;
    logic        rvfi_intr;
    logic [1:0]  rvfi_mode;
    logic [4:0]  rvfi_rs1_addr;
    logic [4:0]  rvfi_rs2_addr;
    logic [31:0] rvfi_rs1_rdata;
    logic [31:0] rvfi_rs2_rdata;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata;
    logic [31:0] rvfi_pc_rdata;
    logic [31:0] rvfi_pc_wdata;
    logic [31:0] rvfi_mem_addr;
    logic [3:0]  rvfi_mem_rmask;
    logic [3:0]  rvfi_mem_wmask;
    logic [31:0] rvfi_mem_rdata;
    logic [31:0] rvfi_mem_wdata;
    logic        rvfi_mem_extamo;
    logic [15:0] errcode;

    int n_vec = 0;
    int n_err = 0;

    rvfi_monitor_rv32imc #(.XLEN(32), .CHECK_REG(1'b1)) dut (
        .clock(clock), .reset(reset),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
        .rvfi_mode(rvfi_mode),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
        .rvfi_mem_wdata(rvfi_mem_wdata), .rvfi_mem_extamo(rvfi_mem_extamo),
        .errcode(errcode)
    );

    always #5 clock = ~clock;

    // Reference model: the architectural view of what the checker has seen
    logic [15:0]     m_err;
    bit              m_first;
    bit              m_halted;
    longint unsigned m_prev_order;
    bit [31:0]       m_prev_pc;
    bit [31:0]       m_rf  [32];
    bit              m_rfv [32];

    function automatic bit rs_bad(input bit [4:0] a, input bit [31:0] d);
        if (a == 5'd0) return d != 32'd0;
        return m_rfv[a] && (m_rf[a] != d);
    endfunction

    function automatic logic [15:0] model_code();
        int q[$];
        int best;
        if (m_first ? (rvfi_order != 64'd0) : (rvfi_order != m_prev_order + 64'd1)) q.push_back('h0101);
        if (!m_first && rvfi_pc_rdata != m_prev_pc)                    q.push_back('h0102);
        if (rvfi_pc_rdata[0] || rvfi_pc_wdata[0])                       q.push_back('h0103);
        if (rs_bad(rvfi_rs1_addr, rvfi_rs1_rdata))                      q.push_back('h0201);
        if (rs_bad(rvfi_rs2_addr, rvfi_rs2_rdata))                      q.push_back('h0202);
        if (rvfi_rd_addr == 5'd0 && rvfi_rd_wdata != 32'd0)             q.push_back('h0203);
        if (!(rvfi_mem_rmask inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF}) ||
            !(rvfi_mem_wmask inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF}))
                                                                        q.push_back('h0301);
        if (rvfi_mem_rmask != 0 && rvfi_mem_wmask != 0 && !rvfi_mem_extamo) q.push_back('h0302);
        if (rvfi_mem_addr[1:0] != 0 && (rvfi_mem_rmask != 0 || rvfi_mem_wmask != 0))
                                                                        q.push_back('h0303);
        if (m_halted)                                                   q.push_back('h0401);
        if (rvfi_trap || rvfi_intr)                                     q.push_back('h0402);
        if (q.size() == 0) return 16'h0000;
        best = q[0];
        foreach (q[i]) if (q[i] < best) best = q[i];
        return 16'(best);
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_err        <= 16'h0000;
            m_first      <= 1'b1;
            m_halted     <= 1'b0;
            m_prev_order <= 0;
            m_prev_pc    <= 32'd0;
            for (int i = 0; i < 32; i++) m_rfv[i] <= 1'b0;
        end else begin
            if (rvfi_valid) begin
                if (m_err == 16'h0000) m_err <= model_code();
                m_prev_order <= rvfi_order;
                m_prev_pc    <= rvfi_pc_wdata;
                m_first      <= 1'b0;
                if (rvfi_rd_addr != 5'd0) begin
                    m_rf[rvfi_rd_addr]  <= rvfi_rd_wdata;
                    m_rfv[rvfi_rd_addr] <= 1'b1;
                end
            end
            if (rvfi_halt) m_halted <= 1'b1;
        end
    end

    task automatic clr();
        rvfi_valid = 0; rvfi_order = 0; rvfi_insn = 32'h00000013;
        rvfi_trap = 0; rvfi_halt = 0; rvfi_intr = 0; rvfi_mode = 2'b11;
        rvfi_rs1_addr = 0; rvfi_rs2_addr = 0; rvfi_rs1_rdata = 0; rvfi_rs2_rdata = 0;
        rvfi_rd_addr = 0; rvfi_rd_wdata = 0; rvfi_pc_rdata = 0; rvfi_pc_wdata = 0;
        rvfi_mem_addr = 0; rvfi_mem_rmask = 0; rvfi_mem_wmask = 0;
        rvfi_mem_rdata = 0; rvfi_mem_wdata = 0; rvfi_mem_extamo = 0;
    endtask

    // Every clock edge goes through here so the model is compared each cycle
    task automatic tick();
        @(posedge clock);
        #1;
        n_vec++;
        if (errcode !== m_err) begin
            n_err++;
            $display("FAIL cycle_compare t=%0t errcode=%h model=%h", $time, errcode, m_err);
        end
        clr();
    endtask

    task automatic expect_lit(input string name, input logic [15:0] want);
        n_vec++;
        if (errcode !== want) begin
            n_err++;
            $display("FAIL %s errcode=%h expected=%h", name, errcode, want);
        end
    endtask

    task automatic beat(input longint unsigned ord, input bit [31:0] pcr, input bit [31:0] pcw);
        rvfi_valid    = 1'b1;
        rvfi_order    = ord;
        rvfi_pc_rdata = pcr;
        rvfi_pc_wdata = pcw;
        tick();
    endtask

    // Reset asserted between edges must clear errcode without a clock
    task automatic do_reset(input string name);
        reset = 1'b0;
        #2;
        expect_lit(name, 16'h0000);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        clr();
        reset = 1'b0;
        #12;
        expect_lit("reset_state", 16'h0000);
        reset = 1'b1;
        tick();

        rvfi_insn = 32'h00500093; rvfi_rd_addr = 1; rvfi_rd_wdata = 5;
        beat(0, 32'h0, 32'h4);
        rvfi_insn = 32'h00108133; rvfi_rs1_addr = 1; rvfi_rs1_rdata = 5;
        rvfi_rs2_addr = 1; rvfi_rs2_rdata = 5; rvfi_rd_addr = 2; rvfi_rd_wdata = 10;
        beat(1, 32'h4, 32'h8);
        expect_lit("addi_add_clean", 16'h0000);
        beat(3, 32'h8, 32'hC);
        expect_lit("order_skip", 16'h0101);
        beat(4, 32'hC, 32'h10);
        tick();
        expect_lit("order_sticky", 16'h0101);
        do_reset("reset_after_order");

        beat(0, 32'h0, 32'hC);
        beat(1, 32'h10, 32'h14);
        expect_lit("pc_flow", 16'h0102);
        do_reset("reset_after_pc_flow");

        rvfi_rd_addr = 1; rvfi_rd_wdata = 5;
        beat(0, 32'h0, 32'h4);
        rvfi_rs1_addr = 1; rvfi_rs1_rdata = 6;
        beat(1, 32'h4, 32'h8);
        expect_lit("rs1_stale", 16'h0201);
        do_reset("reset_after_rs1");

        rvfi_rd_addr = 5; rvfi_rd_wdata = 7;
        beat(0, 32'h0, 32'h4);
        rvfi_rs2_addr = 5; rvfi_rs2_rdata = 8;
        beat(1, 32'h4, 32'h8);
        expect_lit("rs2_stale", 16'h0202);
        do_reset("reset_after_rs2");

        rvfi_rd_addr = 0; rvfi_rd_wdata = 7;
        beat(0, 32'h0, 32'h4);
        expect_lit("x0_write", 16'h0203);
        do_reset("reset_after_x0");

        rvfi_mem_addr = 32'h100; rvfi_mem_wmask = 4'b0110;
        beat(0, 32'h0, 32'h4);
        expect_lit("illegal_wmask", 16'h0301);
        do_reset("reset_after_mask");

        rvfi_mem_addr = 32'h100; rvfi_mem_rmask = 4'b0001; rvfi_mem_wmask = 4'b0001;
        beat(0, 32'h0, 32'h4);
        expect_lit("mixed_no_amo", 16'h0302);
        do_reset("reset_after_mixed");

        rvfi_mem_addr = 32'h100; rvfi_mem_rmask = 4'b0001; rvfi_mem_wmask = 4'b0001;
        rvfi_mem_extamo = 1'b1;
        beat(0, 32'h0, 32'h4);
        expect_lit("mixed_amo_ok", 16'h0000);
        rvfi_rd_addr = 3; rvfi_rd_wdata = 1;
        beat(1, 32'h4, 32'h8);
        rvfi_rs1_addr = 3; rvfi_rs1_rdata = 1; rvfi_rd_addr = 3; rvfi_rd_wdata = 9;
        beat(2, 32'h8, 32'hC);
        rvfi_rs1_addr = 3; rvfi_rs1_rdata = 9;
        beat(3, 32'hC, 32'h10);
        expect_lit("rs_eq_rd_old_value", 16'h0000);
        rvfi_insn = 32'h00004501;
        beat(4, 32'h10, 32'h12);
        rvfi_mem_addr = 32'h102; rvfi_mem_rmask = 4'b0001;
        beat(5, 32'h12, 32'h16);
        expect_lit("misaligned_addr", 16'h0303);
        do_reset("reset_after_misalign");

        beat(0, 32'h0, 32'h5);
        expect_lit("pc_odd", 16'h0103);
        do_reset("reset_after_pc_odd");

        rvfi_trap = 1'b1;
        beat(2, 32'h0, 32'h4);
        expect_lit("priority_order_over_trap", 16'h0101);
        do_reset("reset_after_priority");

        rvfi_intr = 1'b1;
        beat(0, 32'h0, 32'h4);
        expect_lit("intr", 16'h0402);
        do_reset("reset_after_intr");

        beat(0, 32'h0, 32'h4);
        rvfi_halt = 1'b1;
        tick();
        tick();
        expect_lit("halt_no_valid", 16'h0000);
        beat(1, 32'h4, 32'h8);
        expect_lit("valid_after_halt", 16'h0401);
        do_reset("reset_mid_run");
        beat(0, 32'h0, 32'h4);
        tick();
        expect_lit("first_beat_after_reset", 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
